// File: rtl/fifo_word_packer_if.sv
// Handshake bundle between the show-ahead FIFO read port, the packer and the
// downstream valid/ready word stream.
interface fifo_word_packer_if #(
   parameter int WIDTH = 8,
   parameter int RATIO = 4
);
   logic                   fifo_empty;
   logic [WIDTH-1:0]       fifo_rd_data;
   logic                   fifo_rd_en;
   logic                   flush_req;
   logic                   m_valid;
   logic                   m_ready;
   logic [RATIO*WIDTH-1:0] m_data;
   logic [RATIO-1:0]       m_keep;
   logic                   m_partial;

   modport master (
      input  fifo_empty, fifo_rd_data, flush_req, m_ready,
      output fifo_rd_en, m_valid, m_data, m_keep, m_partial
   );

   modport slave (
      output fifo_empty, fifo_rd_data, flush_req, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_keep, m_partial
   );
endinterface

// File: rtl/fifo_word_packer.sv
// Pops RATIO narrow FIFO entries and presents them as one wide word; partial
// words leave on idle timeout or flush, flagged by a contiguous keep mask.
module fifo_word_packer #(
   parameter int WIDTH   = 8,
   parameter int RATIO   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                rst,
   fifo_word_packer_if.master  bus
);
   localparam int IW = (RATIO > 2) ? $clog2(RATIO) : 1;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam int DW = RATIO * WIDTH;
   localparam logic [IW-1:0] LAST_IDX = IW'(RATIO - 1);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_FIRE = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   data_q, data_d;
   logic [RATIO-1:0] keep_q, keep_d;
   logic            valid_q, valid_d;
   logic            partial_q, partial_d;
   logic            pop_s;

   // Lanes fill in place inside the output register, so cleared lanes read 0 in a partial word.
   assign pop_s          = (state_q == FILL) && !bus.fifo_empty && !rst;
   assign bus.fifo_rd_en = pop_s;
   assign bus.m_valid    = valid_q;
   assign bus.m_data     = data_q;
   assign bus.m_keep     = keep_q;
   assign bus.m_partial  = partial_q;

   // Next-state: lane collection, emit decision and downstream handshake.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      keep_d    = keep_q;
      valid_d   = valid_q;
      partial_d = 1'b0;
      case (state_q)
         FILL: begin
            if (pop_s) begin
               data_d[int'(idx_q)*WIDTH +: WIDTH] = bus.fifo_rd_data;
               keep_d[idx_q] = 1'b1;
               cnt_d         = {CW{1'b0}};
               if ((idx_q == LAST_IDX) || bus.flush_req) begin
                  state_d   = HOLD;
                  valid_d   = 1'b1;
                  partial_d = (idx_q != LAST_IDX);
                  idx_d     = {IW{1'b0}};
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else if (idx_q != {IW{1'b0}}) begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  cnt_d = cnt_q;
               end
               // Firing on CNT_FIRE makes valid rise on the edge closing the TIMEOUT-th idle cycle.
               if (bus.flush_req || ((TIMEOUT != 0) && (cnt_q == CNT_FIRE))) begin
                  state_d   = HOLD;
                  valid_d   = 1'b1;
                  partial_d = 1'b1;
                  idx_d     = {IW{1'b0}};
               end else begin
                  idx_d = idx_q;
               end
            end else begin
               cnt_d = cnt_q;
            end
         end
         HOLD: begin
            if (valid_q && bus.m_ready) begin
               state_d = FILL;
               valid_d = 1'b0;
               keep_d  = {RATIO{1'b0}};
               data_d  = {DW{1'b0}};
               cnt_d   = {CW{1'b0}};
            end else begin
               valid_d = valid_q;
            end
         end
         default: begin
            state_d = FILL;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         idx_q     <= {IW{1'b0}};
         cnt_q     <= {CW{1'b0}};
         data_q    <= {DW{1'b0}};
         keep_q    <= {RATIO{1'b0}};
         valid_q   <= 1'b0;
         partial_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         data_q    <= data_d;
         keep_q    <= keep_d;
         valid_q   <= valid_d;
         partial_q <= partial_d;
      end
   end
endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed and random checks of fifo_word_packer against a queue-based model
// of the FIFO and of the word-emission rules.
module tb_fifo_word_packer;
   localparam int WIDTH   = 8;
   localparam int RATIO   = 4;
   localparam int TIMEOUT = 16;
   localparam int DW      = WIDTH * RATIO;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_word_packer_if #(.WIDTH(WIDTH), .RATIO(RATIO)) bus ();

   fifo_word_packer #(.WIDTH(WIDTH), .RATIO(RATIO), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [WIDTH-1:0] fifo_q[$];
   logic [WIDTH-1:0] word_q[$];
   logic [DW-1:0]    got_data[$];
   logic [RATIO-1:0] got_keep[$];
   bit               m_hold;
   int               idle;
   logic             m_valid_e;
   logic [DW-1:0]    m_data_e;
   logic [RATIO-1:0] m_keep_e;
   logic             m_part_e;
   int               checks = 0;
   int               fails  = 0;
   int               n;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      bus.fifo_empty   = (fifo_q.size() == 0);
      bus.fifo_rd_data = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
   endtask

   task automatic push(input logic [WIDTH-1:0] b);
      fifo_q.push_back(b);
      refresh();
   endtask

   task automatic emit();
      m_data_e = '0;
      foreach (word_q[i]) m_data_e = m_data_e | (DW'(word_q[i]) << (i * WIDTH));
      m_keep_e  = RATIO'((1 << word_q.size()) - 1);
      m_part_e  = (word_q.size() < RATIO);
      m_valid_e = 1'b1;
      m_hold    = 1'b1;
      idle      = 0;
      word_q.delete();
   endtask

   // One clock: sample pre-edge inputs, advance FIFO and model, compare outputs.
   task automatic tick();
      logic pop_e, pop_a, fl, rdy, r;
      logic [WIDTH-1:0] head;
      @(negedge clk);
      r     = rst;
      fl    = bus.flush_req;
      rdy   = bus.m_ready;
      head  = bus.fifo_rd_data;
      pop_a = bus.fifo_rd_en;
      pop_e = !m_hold && (fifo_q.size() > 0) && !r;
      chk("rd_en", 64'(pop_a), 64'(pop_e));
      if (bus.m_valid === 1'b1 && rdy && !r) begin
         got_data.push_back(bus.m_data);
         got_keep.push_back(bus.m_keep);
      end
      @(posedge clk);
      #1;
      if (pop_a === 1'b1 && fifo_q.size() > 0) void'(fifo_q.pop_front());
      m_part_e = 1'b0;
      if (r) begin
         word_q.delete();
         m_hold = 1'b0; idle = 0;
         m_valid_e = 1'b0; m_data_e = '0; m_keep_e = '0;
      end else if (m_hold) begin
         if (rdy) begin
            m_hold = 1'b0; idle = 0;
            m_valid_e = 1'b0; m_data_e = '0; m_keep_e = '0;
         end
      end else if (pop_e) begin
         word_q.push_back(head);
         idle = 0;
         if (word_q.size() == RATIO || fl) emit();
      end else if (word_q.size() > 0) begin
         idle++;
         if (fl || (TIMEOUT != 0 && idle >= TIMEOUT)) emit();
      end
      refresh();
      chk("m_valid", 64'(bus.m_valid), 64'(m_valid_e));
      chk("m_partial", 64'(bus.m_partial), 64'(m_part_e));
      if (m_valid_e) begin
         chk("m_data", 64'(bus.m_data), 64'(m_data_e));
         chk("m_keep", 64'(bus.m_keep), 64'(m_keep_e));
      end
   endtask

   task automatic wait_valid(input int limit, input string tag, output int cnt);
      cnt = 0;
      while (bus.m_valid !== 1'b1 && cnt < limit) begin
         tick();
         cnt++;
      end
      chk({tag, "_valid_seen"}, 64'(bus.m_valid), 64'(1'b1));
   endtask

   initial begin
      m_hold = 1'b0; idle = 0; m_valid_e = 1'b0; m_data_e = '0; m_keep_e = '0; m_part_e = 1'b0;
      rst = 1'b1; bus.flush_req = 1'b0; bus.m_ready = 1'b0;
      refresh();

      // Reset, then one full word
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      tick(); tick();
      chk("rst_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_data", 64'(bus.m_data), 64'd0);
      chk("rst_keep", 64'(bus.m_keep), 64'd0);
      chk("rst_partial", 64'(bus.m_partial), 64'd0);
      rst = 1'b0; bus.m_ready = 1'b1;
      wait_valid(10, "full", n);
      chk("full_latency", 64'(n), 64'd4);
      chk("full_data", 64'(bus.m_data), 64'h44332211);
      chk("full_keep", 64'(bus.m_keep), 64'hF);
      chk("full_partial", 64'(bus.m_partial), 64'd0);
      tick();
      chk("full_got_count", 64'(got_data.size()), 64'd1);

      // Backpressure
      bus.m_ready = 1'b0;
      push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
      wait_valid(10, "bp", n);
      repeat (10) begin
         tick();
         chk("bp_data_stable", 64'(bus.m_data), 64'h44332211);
      end
      chk("bp_fifo_left", 64'(fifo_q.size()), 64'd1);
      bus.m_ready = 1'b1;
      tick();
      tick();
      chk("bp_after_pop", 64'(fifo_q.size()), 64'd0);
      bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
      chk("bp_flush_data", 64'(bus.m_data), 64'h55);
      tick();

      // Idle timeout
      push(8'hAA); push(8'hBB);
      tick(); tick();
      wait_valid(40, "tmo", n);
      chk("tmo_latency", 64'(n), 64'(TIMEOUT));
      chk("tmo_data", 64'(bus.m_data), 64'h0000BBAA);
      chk("tmo_keep", 64'(bus.m_keep), 64'h3);
      chk("tmo_partial", 64'(bus.m_partial), 64'd1);
      tick();

      // Flush cases
      push(8'h01);
      tick(); tick(); tick();
      bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
      chk("flush_data", 64'(bus.m_data), 64'h00000001);
      chk("flush_keep", 64'(bus.m_keep), 64'h1);
      tick();
      bus.flush_req = 1'b1;
      repeat (3) tick();
      bus.flush_req = 1'b0;
      chk("flush_idle_novalid", 64'(bus.m_valid), 64'd0);
      push(8'hA1); push(8'hA2);
      tick(); tick();
      push(8'hA3);
      bus.flush_req = 1'b1; tick(); bus.flush_req = 1'b0;
      chk("flush_coinc_keep", 64'(bus.m_keep), 64'h7);
      chk("flush_coinc_data", 64'(bus.m_data), 64'h00A3A2A1);
      tick();

      // Streaming two full words
      got_data.delete(); got_keep.delete();
      for (int i = 0; i < 8; i++) push(8'(i));
      repeat (12) tick();
      chk("stream_count", 64'(got_data.size()), 64'd2);
      if (got_data.size() == 2) begin
         chk("stream_w0", 64'(got_data[0]), 64'h03020100);
         chk("stream_w1", 64'(got_data[1]), 64'h07060504);
      end
      chk("stream_fifo_empty", 64'(bus.fifo_empty), 64'd1);

      // Reset mid-word
      push(8'h20); push(8'h21);
      tick(); tick();
      rst = 1'b1;
      push(8'h10); push(8'h11); push(8'h12); push(8'h13);
      tick();
      rst = 1'b0;
      got_data.delete(); got_keep.delete();
      repeat (8) tick();
      chk("rstmid_count", 64'(got_data.size()), 64'd1);
      if (got_data.size() > 0) begin
         chk("rstmid_data", 64'(got_data[0]), 64'h13121110);
         chk("rstmid_keep", 64'(got_keep[0]), 64'hF);
      end

      // Random traffic against the model
      repeat (1500) begin
         if ($urandom_range(0, 2) == 0 && fifo_q.size() < 16) push(8'($urandom));
         bus.flush_req = ($urandom_range(0, 15) == 0);
         bus.m_ready   = ($urandom_range(0, 3) != 0);
         rst           = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0; bus.flush_req = 1'b0; bus.m_ready = 1'b1;
      repeat (60) tick();
      chk("drain_fifo_empty", 64'(fifo_q.size()), 64'd0);
      chk("drain_idle", 64'(bus.m_valid), 64'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end
endmodule

// File: doc/fifo_word_packer.md
Name: fifo_word_packer

Overview:
- Downstream consumer of the sync FIFO (show-ahead read port: rd_data valid whenever !empty, pop on rd_en at clock edge).
- Pops RATIO narrow WIDTH-bit entries and packs them into one wide RATIO*WIDTH word.
- Presents the packed word on a valid/ready master stream.
- Emits partially filled words on an idle timeout or an explicit flush request, with a per-lane keep mask.

Parameters:
- WIDTH, 8, width of one FIFO entry / one lane
- RATIO, 4, lanes per output word (>=2)
- TIMEOUT, 16, idle cycles before a partial word is emitted; 0 disables timeout

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous reset, active-high
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_data  in  WIDTH  FIFO head entry, valid when !fifo_empty
- fifo_rd_en  out  1  FIFO pop strobe
- flush_req  in  1  request to emit the current partial word
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  RATIO*WIDTH  packed word; lane 0 = bits [WIDTH-1:0] = first popped entry
- m_keep  out  RATIO  lane-valid mask, contiguous from bit 0
- m_partial  out  1  one-cycle pulse when a partial word (keep != all-ones) is loaded

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: m_valid=0, m_data=0, m_keep=0, m_partial=0, state=FILL, lane index idx=0, idle counter=0.
  - fifo_rd_en is combinational and forced 0 while rst=1.
- States: FILL (collecting entries) and HOLD (word presented, waiting for handshake).
- fifo_rd_en = (state==FILL) && !fifo_empty && !rst. Pop = fifo_rd_en.
  - Pops are never issued in HOLD, including the handshake cycle.
- FILL, on pop:
  - lane[idx] <= fifo_rd_data; keep[idx] <= 1; idle counter <= 0.
  - If idx==RATIO-1: idx <= 0, go to HOLD, m_valid <= 1 (valid one cycle after the 4th pop edge). Otherwise idx <= idx+1.
- FILL, no pop, idx>0:
  - Idle counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT, go to HOLD with the partial word: m_valid rises on the edge ending the TIMEOUT-th consecutive idle cycle.
- flush_req in FILL:
  - idx>0 with no pop that cycle: go to HOLD with the partial word next edge.
  - Coincident with a pop: the popped entry is included, then emit (full or partial).
  - idx==0 and no pop: ignored (no empty words ever emitted).
  - flush_req in HOLD: ignored.
- Partial words: unused lanes of m_data are 0, m_keep reflects the filled lanes, and m_partial pulses 1 on the cycle m_valid rises.
- HOLD:
  - m_data, m_keep and m_valid are stable until m_valid && m_ready.
  - On handshake: next edge m_valid=0, m_keep=0, m_data=0, idle counter=0, state=FILL.
  - Best-case throughput: one word per RATIO+1 cycles.
- m_ready is ignored while m_valid=0. No combinational path from m_ready to m_valid/m_data.
- Reset asserted mid-word or in HOLD: the partial/held word is discarded and all state returns to reset values on that edge. Entries already popped are lost by design.
- Widths:
  - idx is $clog2(RATIO) bits (min 1).
  - Idle counter is $clog2(TIMEOUT+1) bits (min 1) and saturates; it never wraps.

Test Plan:
- Reset, RATIO=4: FIFO holds 0x11,0x22,0x33,0x44, m_ready=1 -> four consecutive pops; m_valid=1 the cycle after the 4th pop with m_data=0x44332211, m_keep=4'b1111, m_partial=0; handshake then FILL.
- Backpressure: word 0x44332211 held with m_ready=0 for 10 cycles while FIFO has 0x55 -> fifo_rd_en=0 throughout; m_data stable. m_ready=1 -> handshake, then 0x55 popped next cycle.
- Timeout, TIMEOUT=16: push 0xAA,0xBB then stop -> m_valid rises 16 idle cycles after 2nd pop; m_data=0x0000BBAA, m_keep=4'b0011, m_partial pulses once.
- Flush: 0x01 popped, flush_req pulsed 3 cycles later -> m_data=0x00000001, m_keep=4'b0001. flush_req with idx=0 -> no m_valid. flush_req coincident with 3rd pop -> keep=4'b0111.
- Streaming: 8 entries 0x00..0x07, m_ready=1 -> two words 0x03020100 then 0x07060504, no entry lost or duplicated, FIFO empty at end.
- Reset mid-word after 2 pops, then push 0x10..0x13 -> first output 0x13121110 keep 4'b1111; discarded entries never appear.
